// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Load/store unit for the MEM stage of the 5-stage RV32I pipeline. It sits
// between the EX/MEM and MEM/WB pipeline registers. It turns the EX/MEM
// load/store control into a request/ready transaction on the data memory port.
// It formats load data for MEM/WB. While an access is in flight it stalls the
// upstream stages.
//
// Parameters
//   ADDR_W            data memory byte-address width
//
// Ports
//   clk               clock
//   reset             synchronous active-high reset
//   EX_MEM_MemRead    load in MEM stage
//   EX_MEM_MemWrite   store in MEM stage (wins when both are set)
//   EX_MEM_funct3     RV32I load/store funct3 (size / sign)
//   EX_MEM_ALUResult  effective byte address
//   EX_MEM_RData2     store data (rs2)
//   dmem_req          memory request, held until dmem_ready
//   dmem_we           1 = write
//   dmem_addr         word-aligned address
//   dmem_wdata        lane-replicated store data
//   dmem_be           byte enables
//   dmem_ready        memory completes the access this cycle
//   dmem_rdata        read word, valid with dmem_ready
//   RData             formatted load result for MEM/WB
//   Mem_Stall         hold PC, IF/ID, ID/EX and EX/MEM
//   Misaligned        current access is misaligned (combinational)
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EX_MEM_MemRead,
  input  logic              EX_MEM_MemWrite,
  input  logic [2:0]        EX_MEM_funct3,
  input  logic [31:0]       EX_MEM_ALUResult,
  input  logic [31:0]       EX_MEM_RData2,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       RData,
  output logic              Mem_Stall,
  output logic              Misaligned
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  state_t      state;
  size_t       size;
  logic        mem_op;
  logic        is_store;
  logic        access;
  logic [1:0]  offset;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // Attributes of the access in flight, captured when it leaves IDLE. The
  // load formatter uses these, not the live EX/MEM inputs.
  logic        req_load;
  logic [2:0]  req_f3;
  logic [1:0]  req_off;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] ld_data;

  // Access size decode. A store treats any funct3 other than SB/SH as a word.
  // A load ignores funct3[2] (the unsigned flag) when it picks the size, so
  // LBU/LHU get the same alignment rules as LB/LH.
  always_comb begin
    mem_op   = EX_MEM_MemRead | EX_MEM_MemWrite;
    is_store = EX_MEM_MemWrite;
    offset   = EX_MEM_ALUResult[1:0];
    size     = SZ_WORD;
    if (is_store) begin
      case (EX_MEM_funct3)
        3'b000:  size = SZ_BYTE;
        3'b001:  size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end else begin
      case (EX_MEM_funct3[1:0])
        2'b00:   size = SZ_BYTE;
        2'b01:   size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end
  end

  assign Misaligned = mem_op &
                      (((size == SZ_HALF) & offset[0]) |
                       ((size == SZ_WORD) & (offset != 2'b00)));

  assign access = mem_op & ~Misaligned;

  // The stall drops in DONE so the pipeline advances at the end of that cycle.
  // That is the same edge at which MEM/WB samples RData.
  assign Mem_Stall = access & (state != DONE);

  // Store lane encoding. The data is replicated across lanes so that the byte
  // enables alone choose the bytes that memory writes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = EX_MEM_RData2;
    case (size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << offset;
        st_wdata = {4{EX_MEM_RData2[7:0]}};
      end
      SZ_HALF: begin
        st_be    = 4'b0011 << offset;
        st_wdata = {2{EX_MEM_RData2[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = EX_MEM_RData2;
      end
    endcase
  end

  // Load formatting uses the byte offset and funct3 of the request in flight.
  always_comb begin
    case (req_off)
      2'd0:    lane_byte = dmem_rdata[7:0];
      2'd1:    lane_byte = dmem_rdata[15:8];
      2'd2:    lane_byte = dmem_rdata[23:16];
      default: lane_byte = dmem_rdata[31:24];
    endcase
    lane_half = req_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (req_f3)
      3'b000:  ld_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  ld_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  ld_data = {24'd0, lane_byte};
      3'b101:  ld_data = {16'd0, lane_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // Access FSM with registered memory-port outputs. The EX/MEM inputs are
  // frozen by Mem_Stall while the FSM is in REQ. Even so, the request is
  // captured once in IDLE so that the port stays stable no matter what
  // upstream does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      RData      <= '0;
      req_load   <= 1'b0;
      req_f3     <= '0;
      req_off    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {EX_MEM_ALUResult[ADDR_W-1:2], 2'b00};
            dmem_wdata <= is_store ? st_wdata : 32'd0;
            dmem_be    <= is_store ? st_be : 4'b1111;
            req_load   <= ~is_store;
            req_f3     <= EX_MEM_funct3;
            req_off    <= offset;
            state      <= REQ;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (req_load) begin
              RData <= ld_data;
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
//
// Scoreboard bench for mem_stage_lsu. The stimulus process runs each
// instruction through a byte-level reference model and queues the memory
// transaction it expects, including the load result. A monitor pops the queue
// on every request/ready handshake and checks RData one cycle later, in DONE.
// A memory responder serves the port with a programmable ready delay.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic [2:0]  EX_MEM_funct3;
  logic [31:0] EX_MEM_ALUResult;
  logic [31:0] EX_MEM_RData2;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] RData;
  logic        Mem_Stall;
  logic        Misaligned;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .EX_MEM_MemRead   (EX_MEM_MemRead),
    .EX_MEM_MemWrite  (EX_MEM_MemWrite),
    .EX_MEM_funct3    (EX_MEM_funct3),
    .EX_MEM_ALUResult (EX_MEM_ALUResult),
    .EX_MEM_RData2    (EX_MEM_RData2),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_be          (dmem_be),
    .dmem_ready       (dmem_ready),
    .dmem_rdata       (dmem_rdata),
    .RData            (RData),
    .Mem_Stall        (Mem_Stall),
    .Misaligned       (Misaligned)
  );

  typedef struct {
    logic        is_store;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] last_rdata;
  int          resp_delay = 0;
  bit          pulse_ready = 1'b0;

  function automatic logic [31:0] init_word(int i);
    if (i == 64) return 32'hDEADBEEF;
    return 32'(i) * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // Bytes touched by an access, from the RV32I funct3 meaning.
  function automatic int access_size(bit store, logic [2:0] f3);
    if (store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: raises ready after resp_delay wait cycles of a held
  // request, and commits store bytes at that handshake.
  initial begin
    int wait_cnt;
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    wait_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      dmem_ready = 1'b0;
      if (pulse_ready) begin
        dmem_ready = 1'b1;
        dmem_rdata = $urandom;
      end else if (dmem_req) begin
        if (wait_cnt >= resp_delay) begin
          dmem_ready = 1'b1;
          dmem_rdata = mem[dmem_addr[11:2]];
          if (dmem_we) begin
            for (int l = 0; l < 4; l++)
              if (dmem_be[l]) mem[dmem_addr[11:2]][8*l +: 8] = dmem_wdata[8*l +: 8];
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares each handshake with the scoreboard head, then checks
  // RData in the following (DONE) cycle.
  initial begin
    bit          pend;
    logic [31:0] pend_rdata;
    exp_t        e;
    pend = 1'b0;
    pend_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          checkOutput("rdata", RData, pend_rdata);
          pend = 1'b0;
        end
        if (dmem_req && dmem_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_req", {31'd0, dmem_req}, 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("we", {31'd0, dmem_we}, {31'd0, e.is_store});
            checkOutput("addr", dmem_addr, e.addr);
            checkOutput("be", {28'd0, dmem_be}, {28'd0, e.be});
            if (e.is_store) checkOutput("wdata", dmem_wdata, e.wdata);
            pend       = 1'b1;
            pend_rdata = e.rdata;
          end
        end
      end
    end
  end

  // Runs one instruction through the reference model, queues the expected
  // transaction, then holds the inputs until the DUT releases the stall.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] rs2, input int delay);
    int          size, o, stalls, exp_stalls;
    bit          mis, act, done;
    exp_t        e;
    logic [31:0] word, v, data;
    size = access_size(wr, f3);
    o    = int'(addr[1:0]);
    mis  = (rd || wr) && ((addr % size) != 0);
    act  = (rd || wr) && !mis;
    if (act) begin
      word = ref_mem[addr[11:2]];
      e.is_store = wr;
      e.addr     = {addr[31:2], 2'b00};
      if (wr) begin
        data = (size == 4) ? rs2 : (rs2 & ((32'd1 << (8 * size)) - 32'd1));
        e.wdata = (size == 1) ? data * 32'h01010101 : (size == 2) ? data * 32'h00010001 : data;
        e.be    = 4'(((1 << size) - 1) << o);
        for (int k = 0; k < size; k++)
          word = (word & ~(32'hFF << (8 * (o + k)))) | (((rs2 >> (8 * k)) & 32'hFF) << (8 * (o + k)));
        ref_mem[addr[11:2]] = word;
      end else begin
        case (f3)
          3'd0: begin v = (word >> (8 * o)) & 32'hFF;   if (v >= 128)   v = v + 32'hFFFFFF00; end
          3'd1: begin v = (word >> (8 * o)) & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF0000; end
          3'd4: v = (word >> (8 * o)) & 32'hFF;
          3'd5: v = (word >> (8 * o)) & 32'hFFFF;
          default: v = word;
        endcase
        last_rdata = v;
        e.wdata = 32'd0;
        e.be    = 4'hF;
      end
      e.rdata = last_rdata;
      sb.push_back(e);
    end
    resp_delay       = delay;
    EX_MEM_MemRead   = rd;
    EX_MEM_MemWrite  = wr;
    EX_MEM_funct3    = f3;
    EX_MEM_ALUResult = addr;
    EX_MEM_RData2    = rs2;
    exp_stalls = act ? delay + 2 : 0;
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checkOutput("misaligned", {31'd0, Misaligned}, {31'd0, mis});
        if (!act) checkOutput("no_req", {31'd0, dmem_req}, 32'd0);
      end
      if (Mem_Stall) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL stall_timeout: stall still high after 60 cycles, expected release");
    end
    checkOutput("stall_cycles", 32'(stalls), 32'(exp_stalls));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] addr, rs2;
    logic [2:0]  f3;
    int          kind, sz;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    last_rdata       = 32'd0;
    reset            = 1'b1;
    EX_MEM_MemRead   = 1'b0;
    EX_MEM_MemWrite  = 1'b0;
    EX_MEM_funct3    = 3'd0;
    EX_MEM_ALUResult = 32'd0;
    EX_MEM_RData2    = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req",   {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_we",    {31'd0, dmem_we}, 32'd0);
    checkOutput("rst_addr",  dmem_addr, 32'd0);
    checkOutput("rst_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_be",    {28'd0, dmem_be}, 32'd0);
    checkOutput("rst_rdata", RData, 32'd0);
    checkOutput("rst_stall", {31'd0, Mem_Stall}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases
    applyStimulus(1, 0, 3'b010, 32'h100, 32'd0, 0);          // LW -> DEADBEEF
    applyStimulus(0, 1, 3'b010, 32'h100, 32'h80FF0000, 1);   // SW
    applyStimulus(1, 0, 3'b000, 32'h103, 32'd0, 0);          // LB -> FFFFFF80
    applyStimulus(1, 0, 3'b100, 32'h103, 32'd0, 0);          // LBU -> 00000080
    applyStimulus(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 3);   // SH, slow memory
    applyStimulus(1, 0, 3'b010, 32'h101, 32'd0, 0);          // misaligned LW
    applyStimulus(1, 0, 3'b001, 32'h102, 32'd0, 0);          // aligned LH
    applyStimulus(0, 1, 3'b010, 32'h10, 32'hCAFEF00D, 0);    // SW then LW back to back
    applyStimulus(1, 0, 3'b010, 32'h10, 32'd0, 0);
    applyStimulus(0, 0, 3'b010, 32'h44, 32'd0, 0);           // no access
    applyStimulus(1, 1, 3'b000, 32'h21, 32'h5A, 0);          // both set -> SB

    // Randomised mix
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 4095));
      rs2  = $urandom;
      sz   = access_size(kind >= 5, f3);
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(sz - 1);
      applyStimulus(kind >= 1 && kind <= 4 || kind == 9, kind >= 5, f3, addr, rs2,
                    $urandom_range(0, 3));
    end

    // Reset while a load waits in REQ
    resp_delay       = 1000;
    EX_MEM_MemRead   = 1'b1;
    EX_MEM_MemWrite  = 1'b0;
    EX_MEM_funct3    = 3'b010;
    EX_MEM_ALUResult = 32'h40;
    repeat (2) @(negedge clk);
    checkOutput("req_before_reset", {31'd0, dmem_req}, 32'd1);
    @(posedge clk);
    #1;
    reset          = 1'b1;
    EX_MEM_MemRead = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_req",   {31'd0, dmem_req}, 32'd0);
    checkOutput("post_rst_stall", {31'd0, Mem_Stall}, 32'd0);
    checkOutput("post_rst_rdata", RData, 32'd0);
    pulse_ready = 1'b1;
    @(negedge clk);
    pulse_ready = 1'b0;
    checkOutput("pulse_ready_seen", {31'd0, dmem_ready}, 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("pulse_req",   {31'd0, dmem_req}, 32'd0);
    checkOutput("pulse_rdata", RData, 32'd0);
    checkOutput("pulse_stall", {31'd0, Mem_Stall}, 32'd0);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
